axi_protocol_checker: RTL and testbench
=======================================

Name: axi_protocol_checker

Overview:
- Synthesizable, passive AXI4 protocol checker with parametrised widths.
- Sits beside the AXI interface and observes all five channels (AW, W, B, AR, R); it never drives the bus.
- Checks valid/payload stability, write-burst length against WLAST, and response ordering against outstanding-transaction counters.
- Reports violations as sticky per-rule flags plus a one-cycle pulse, for both the UVM env and on-chip debug.

Parameters:
ADDR_WIDTH, 32, address width of AW/AR channels
DATA_WIDTH, 64, data width of W/R channels; STRB_WIDTH = DATA_WIDTH/8
ID_WIDTH, 32, ID width on all channels
MAX_OUTSTANDING, 8, AW-length FIFO depth and read-outstanding limit (≥2)
CNT_W, $clog2(MAX_OUTSTANDING+1), width of pending counters

Ports:
sig_clock  in  1  clock, all logic on rising edge
sig_reset  in  1  synchronous, active-low reset
check_en  in  1  1 = rules evaluated; 0 = flags held, no new errors (tracking continues)
clr_err  in  1  synchronous clear of err_sticky
awid/awaddr/awlen/awsize/awburst/awvalid/awready  in  ID_WIDTH/ADDR_WIDTH/8/3/2/1/1  AW channel
wdata/wstrb/wlast/wvalid/wready  in  DATA_WIDTH/STRB_WIDTH/1/1/1  W channel
bid/bresp/bvalid/bready  in  ID_WIDTH/2/1/1  B channel
arid/araddr/arlen/arsize/arburst/arvalid/arready  in  ID_WIDTH/ADDR_WIDTH/8/3/2/1/1  AR channel
rid/rdata/rresp/rlast/rvalid/rready  in  ID_WIDTH/DATA_WIDTH/2/1/1/1  R channel
err_sticky  out  12  per-rule sticky flags (bit map below)
err_pulse  out  1  high one cycle when any flag newly sets
wr_pending  out  CNT_W  AW bursts accepted and not yet fully written
rd_pending  out  CNT_W  AR bursts accepted and not yet completed by RLAST

Behaviour:
- Reset: sig_reset==0 at an edge zeroes err_sticky, err_pulse, wr_pending, rd_pending, the FIFO, the beat counter, wr_done and stall snapshots. Reset mid-burst discards all tracking; no error is raised.
- Handshake: a channel fires when valid&ready at the edge.
- Latency: a violation at edge N sets its flag and err_pulse visible after edge N (registered). err_pulse is high only if some bit goes 0→1 that cycle.
- clr_err has priority over a new error in the same cycle; err_sticky reads 0 the following cycle.
- Stability (bits 0–4 = AW, W, B, AR, R): if the previous cycle had valid=1 and ready=0, then this cycle valid must be 1 and payload must equal the snapshot.
  - AW/AR payload: id, addr, len, size, burst.
  - W payload: data, strb, last.
  - B payload: id, resp.
  - R payload: id, data, resp, last.
- Write-burst tracking: an AW-length FIFO (depth MAX_OUTSTANDING) is pushed on each AW fire; a beat counter counts W fires from 0.
  - On each W fire, compare against the head length L.
  - wlast=1 with beat<L sets bit 5 (early WLAST).
  - wlast=0 with beat==L sets bit 6 (missing WLAST); the burst is still retired.
  - Retiring a burst pops the FIFO and resets the beat counter to 0.
  - Bypass: if the FIFO is empty and AW and W fire in the same cycle, the incoming awlen is used directly with no error.
  - W fires with the FIFO empty and no same-cycle AW set bit 11; the beat is ignored.
- Overflow: an AW fire when the FIFO is full and no same-cycle pop sets bit 9; that push is dropped. A same-cycle pop and push at full is legal.
- wr_pending = FIFO occupancy.
- wr_done counter: +1 on each burst retire, −1 on each B fire.
  - A B fire with wr_done==0 sets bit 7, including when the retire happens in the same cycle, because B must strictly follow the last W beat.
  - wr_done saturates at 0.
- Read tracking: rd_pending +1 on AR fire and −1 on R fire with rlast.
  - Simultaneous AR and R-last fires leave rd_pending unchanged.
  - Any R fire with rd_pending==0 sets bit 8, even if AR fires the same cycle; the counter stays at 0.
  - An AR fire at rd_pending==MAX_OUTSTANDING with no same-cycle R-last sets bit 10; the count saturates.
- Bit map: 0 AW stab, 1 W stab, 2 B stab, 3 AR stab, 4 R stab, 5 early WLAST, 6 missing WLAST, 7 orphan B, 8 orphan R, 9 AW overflow, 10 AR overflow, 11 W without AW.
- check_en=0 masks flag setting only. FIFO and counters keep tracking so that re-enabling mid-traffic does not produce false errors.

Test Plan:
- AW awlen=3, then 4 W beats with wlast on beat 3, then B → err_sticky=0, wr_pending 1→0, err_pulse never high.
- awvalid=1, awready=0, awaddr changes 0x100→0x104 on the next cycle → err_sticky[0]=1 one cycle later, err_pulse high exactly 1 cycle; clr_err → 0.
- AW awlen=1, W wlast=1 on beat 0 → bit 5. Separately, awlen=0 with wlast=0 → bit 6, and the next burst is checked cleanly.
- MAX_OUTSTANDING=8: 8 AW with no W, then a 9th AW → bit 9, wr_pending=8. Then a 9th AW in the same cycle as a wlast retire → no error, wr_pending stays 8.
- B fire with no writes; R fire in the same cycle as the first AR → bits 7 and 8 set, rd_pending=1 after.
- Assert sig_reset=0 mid-burst (2 of 4 beats done), release, then run a full fresh burst → no errors, all counters start from 0.

Source files
------------

// File: rtl/axi_protocol_checker.sv
// Passive AXI4 protocol checker: watches all five channels and raises sticky per-rule
// flags for handshake stability, write-burst length, response ordering and overflow.
module axi_protocol_checker #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 64,
  parameter int ID_WIDTH        = 32,
  parameter int MAX_OUTSTANDING = 8,
  parameter int STRB_WIDTH      = DATA_WIDTH/8,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING+1)
) (
  input  logic                  sig_clock,
  input  logic                  sig_reset,
  input  logic                  check_en,
  input  logic                  clr_err,
  input  logic [ID_WIDTH-1:0]   awid,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [7:0]            awlen,
  input  logic [2:0]            awsize,
  input  logic [1:0]            awburst,
  input  logic                  awvalid,
  input  logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0] wstrb,
  input  logic                  wlast,
  input  logic                  wvalid,
  input  logic                  wready,
  input  logic [ID_WIDTH-1:0]   bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  input  logic                  bready,
  input  logic [ID_WIDTH-1:0]   arid,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [7:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  input  logic                  arvalid,
  input  logic                  arready,
  input  logic [ID_WIDTH-1:0]   rid,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  input  logic                  rready,
  output logic [11:0]           err_sticky,
  output logic                  err_pulse,
  output logic [CNT_W-1:0]      wr_pending,
  output logic [CNT_W-1:0]      rd_pending
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int AX_W  = ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2;
  localparam int W_W   = DATA_WIDTH + STRB_WIDTH + 1;
  localparam int B_W   = ID_WIDTH + 2;
  localparam int R_W   = ID_WIDTH + DATA_WIDTH + 2 + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING-1)) ? '0 : p + 1'b1;
  endfunction

  logic [AX_W-1:0] w_aw_pl, w_ar_pl, r_aw_snap, r_ar_snap;
  logic [W_W-1:0]  w_w_pl, r_w_snap;
  logic [B_W-1:0]  w_b_pl, r_b_snap;
  logic [R_W-1:0]  w_r_pl, r_r_snap;
  logic            r_aw_stall, r_w_stall, r_b_stall, r_ar_stall, r_r_stall;

  assign w_aw_pl = {awid, awaddr, awlen, awsize, awburst};
  assign w_ar_pl = {arid, araddr, arlen, arsize, arburst};
  assign w_w_pl  = {wdata, wstrb, wlast};
  assign w_b_pl  = {bid, bresp};
  assign w_r_pl  = {rid, rdata, rresp, rlast};

  // Payload is captured every cycle; it only matters when the stall flag is set.
  always_ff @(posedge sig_clock) begin
    if (!sig_reset) begin
      r_aw_stall <= 1'b0; r_w_stall <= 1'b0; r_b_stall <= 1'b0;
      r_ar_stall <= 1'b0; r_r_stall <= 1'b0;
      r_aw_snap  <= '0;   r_w_snap  <= '0;   r_b_snap  <= '0;
      r_ar_snap  <= '0;   r_r_snap  <= '0;
    end else begin
      r_aw_stall <= awvalid & ~awready;
      r_w_stall  <= wvalid & ~wready;
      r_b_stall  <= bvalid & ~bready;
      r_ar_stall <= arvalid & ~arready;
      r_r_stall  <= rvalid & ~rready;
      r_aw_snap  <= w_aw_pl; r_w_snap <= w_w_pl; r_b_snap <= w_b_pl;
      r_ar_snap  <= w_ar_pl; r_r_snap <= w_r_pl;
    end
  end

  logic w_aw_fire, w_w_fire, w_b_fire, w_ar_fire, w_r_fire, w_rlast_fire;
  assign w_aw_fire    = awvalid & awready;
  assign w_w_fire     = wvalid & wready;
  assign w_b_fire     = bvalid & bready;
  assign w_ar_fire    = arvalid & arready;
  assign w_r_fire     = rvalid & rready;
  assign w_rlast_fire = w_r_fire & rlast;

  logic [7:0]       r_fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [CNT_W-1:0] r_fifo_cnt, r_rd_pending;
  logic [CNT_W:0]   r_wr_done;
  logic [7:0]       r_beat, w_head_len;
  logic             w_fifo_empty, w_fifo_full, w_bypass, w_w_active, w_retire;
  logic             w_pop, w_push, w_rd_empty, w_rd_full, w_rd_inc, w_rd_dec;

  assign w_fifo_empty = (r_fifo_cnt == '0);
  assign w_fifo_full  = (r_fifo_cnt == MAX_CNT);
  // With an empty FIFO the same-cycle AW supplies the length directly.
  assign w_bypass     = w_fifo_empty & w_aw_fire & w_w_fire;
  assign w_head_len   = w_bypass ? awlen : r_fifo[r_rptr];
  assign w_w_active   = w_w_fire & (~w_fifo_empty | w_aw_fire);
  assign w_retire     = w_w_active & (wlast | (r_beat == w_head_len));
  assign w_pop        = w_retire & ~w_fifo_empty;
  assign w_push       = w_aw_fire & ~(w_fifo_full & ~w_pop) & ~(w_bypass & w_retire);

  assign w_rd_empty   = (r_rd_pending == '0);
  assign w_rd_full    = (r_rd_pending == MAX_CNT);
  assign w_rd_dec     = w_rlast_fire & ~w_rd_empty;
  assign w_rd_inc     = w_ar_fire & ~(w_rd_full & ~w_rd_dec);

  logic [11:0] w_err, w_err_new;
  always_comb begin
    w_err     = '0;
    w_err[0]  = r_aw_stall & (~awvalid | (w_aw_pl != r_aw_snap));
    w_err[1]  = r_w_stall  & (~wvalid  | (w_w_pl  != r_w_snap));
    w_err[2]  = r_b_stall  & (~bvalid  | (w_b_pl  != r_b_snap));
    w_err[3]  = r_ar_stall & (~arvalid | (w_ar_pl != r_ar_snap));
    w_err[4]  = r_r_stall  & (~rvalid  | (w_r_pl  != r_r_snap));
    w_err[5]  = w_w_active & wlast & (r_beat < w_head_len);
    w_err[6]  = w_w_active & ~wlast & (r_beat == w_head_len);
    w_err[7]  = w_b_fire & (r_wr_done == '0);
    w_err[8]  = w_r_fire & w_rd_empty;
    w_err[9]  = w_aw_fire & w_fifo_full & ~w_pop;
    w_err[10] = w_ar_fire & w_rd_full & ~w_rd_dec;
    w_err[11] = w_w_fire & w_fifo_empty & ~w_aw_fire;
    w_err_new = check_en ? w_err : '0;
  end

  logic [11:0] r_err_sticky;
  logic        r_err_pulse;

  always_ff @(posedge sig_clock) begin
    if (!sig_reset) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) r_fifo[i] <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_fifo_cnt   <= '0;
      r_beat       <= '0;
      r_wr_done    <= '0;
      r_rd_pending <= '0;
      r_err_sticky <= '0;
      r_err_pulse  <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= awlen;
        r_wptr         <= ptr_inc(r_wptr);
      end
      if (w_pop) r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase

      if (w_retire)        r_beat <= '0;
      else if (w_w_active) r_beat <= r_beat + 8'd1;

      case ({w_retire, w_b_fire})
        2'b10:   if (r_wr_done != '1) r_wr_done <= r_wr_done + 1'b1;
        2'b01:   if (r_wr_done != '0) r_wr_done <= r_wr_done - 1'b1;
        default: r_wr_done <= r_wr_done;
      endcase

      case ({w_rd_inc, w_rd_dec})
        2'b10:   r_rd_pending <= r_rd_pending + 1'b1;
        2'b01:   r_rd_pending <= r_rd_pending - 1'b1;
        default: r_rd_pending <= r_rd_pending;
      endcase

      if (clr_err) begin
        r_err_sticky <= '0;
        r_err_pulse  <= 1'b0;
      end else begin
        r_err_sticky <= r_err_sticky | w_err_new;
        r_err_pulse  <= |(w_err_new & ~r_err_sticky);
      end
    end
  end

  assign err_sticky = r_err_sticky;
  assign err_pulse  = r_err_pulse;
  assign wr_pending = r_fifo_cnt;
  assign rd_pending = r_rd_pending;

endmodule

// File: tb/tb_axi_protocol_checker.sv
// Directed bench for axi_protocol_checker: stimulus queues expected flag/counter
// snapshots, a negedge monitor pops and compares them against the DUT.
module tb_axi_protocol_checker;
  localparam int AW = 32, DW = 64, IW = 32, MO = 8, SW = DW/8, CW = $clog2(MO+1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          sig_reset, check_en, clr_err;
  logic [IW-1:0] awid, bid, arid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, arsize;
  logic [1:0]    awburst, arburst, bresp, rresp;
  logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic          arvalid, arready, rvalid, rready, rlast;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic [11:0]   err_sticky;
  logic          err_pulse;
  logic [CW-1:0] wr_pending, rd_pending;

  axi_protocol_checker #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MO)
  ) dut (
    .sig_clock(clk), .sig_reset(sig_reset), .check_en(check_en), .clr_err(clr_err),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .err_sticky(err_sticky), .err_pulse(err_pulse),
    .wr_pending(wr_pending), .rd_pending(rd_pending)
  );

  typedef struct {
    string       name;
    logic [11:0] sticky;
    logic        pulse;
    logic [CW-1:0] wp;
    logic [CW-1:0] rp;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_checks = 0;

  task automatic push_exp(input string nm, input logic [11:0] s, input logic p,
                          input int wp, input int rp);
    exp_t e;
    e.name = nm; e.sticky = s; e.pulse = p; e.wp = CW'(wp); e.rp = CW'(rp);
    q.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      n_checks++;
      if (err_sticky === e.sticky && err_pulse === e.pulse &&
          wr_pending === e.wp && rd_pending === e.rp) begin
        n_pass++;
        $display("check %s ok: sticky=%03h pulse=%0b wp=%0d rp=%0d",
                 e.name, err_sticky, err_pulse, wr_pending, rd_pending);
      end else begin
        $display("FAIL %s: got sticky=%03h pulse=%0b wp=%0d rp=%0d, want sticky=%03h pulse=%0b wp=%0d rp=%0d",
                 e.name, err_sticky, err_pulse, wr_pending, rd_pending,
                 e.sticky, e.pulse, e.wp, e.rp);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    awvalid = 0; wvalid = 0; bvalid = 0; arvalid = 0; rvalid = 0;
    wlast = 0; rlast = 0; clr_err = 0;
  endtask

  task automatic clear_flags(input string nm, input int wp, input int rp);
    clr_err = 1; cyc(); clr_err = 0;
    push_exp(nm, 12'h000, 1'b0, wp, rp);
  endtask

  // Clean burst of len+1 beats followed by its B response.
  task automatic write_burst(input logic [7:0] len, input string tag);
    awlen = len; awaddr = 32'h1000; awid = 5; awvalid = 1;
    cyc(); awvalid = 0;
    push_exp({tag, "_aw"}, 12'h000, 1'b0, 1, 0);
    wvalid = 1;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = DW'(i); wlast = (i == int'(len));
      cyc();
    end
    wvalid = 0; wlast = 0;
    push_exp({tag, "_w"}, 12'h000, 1'b0, 0, 0);
    bvalid = 1; cyc(); bvalid = 0;
    push_exp({tag, "_b"}, 12'h000, 1'b0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    sig_reset = 0; check_en = 1; idle();
    awid = 0; awaddr = 0; awlen = 0; awsize = 3; awburst = 1;
    wdata = 0; wstrb = '1; bid = 0; bresp = 0;
    arid = 0; araddr = 0; arlen = 0; arsize = 3; arburst = 1;
    rid = 0; rdata = 0; rresp = 0;
    awready = 1; wready = 1; bready = 1; arready = 1; rready = 1;
    cyc(); cyc();
    push_exp("reset", 12'h000, 1'b0, 0, 0);
    sig_reset = 1;

    write_burst(8'd3, "t1");

    // Stalled AW whose address changes under the stall.
    awlen = 0; awid = 0; awaddr = 32'h100; awvalid = 1; awready = 0;
    cyc();
    awaddr = 32'h104; cyc();
    push_exp("t2_stab", 12'h001, 1'b1, 0, 0);
    cyc();
    push_exp("t2_pulse_once", 12'h001, 1'b0, 0, 0);
    awready = 1; cyc(); awvalid = 0;
    push_exp("t2_fire", 12'h001, 1'b0, 1, 0);
    clear_flags("t2_clr", 1, 0);
    wvalid = 1; wlast = 1; cyc(); wvalid = 0; wlast = 0;
    bvalid = 1; cyc(); bvalid = 0;
    push_exp("t2_drain", 12'h000, 1'b0, 0, 0);

    // Early WLAST on a 2-beat burst.
    awlen = 1; awvalid = 1; cyc(); awvalid = 0;
    wvalid = 1; wlast = 1; cyc(); wvalid = 0; wlast = 0;
    push_exp("t3_early", 12'h020, 1'b1, 0, 0);
    bvalid = 1; cyc(); bvalid = 0;
    push_exp("t3_early_b", 12'h020, 1'b0, 0, 0);
    clear_flags("t3_clr1", 0, 0);
    // Missing WLAST on a 1-beat burst.
    awlen = 0; awvalid = 1; cyc(); awvalid = 0;
    wvalid = 1; wlast = 0; cyc(); wvalid = 0;
    push_exp("t3_missing", 12'h040, 1'b1, 0, 0);
    bvalid = 1; cyc(); bvalid = 0;
    clear_flags("t3_clr2", 0, 0);
    // Next burst uses the empty-FIFO bypass, then finishes cleanly.
    awlen = 1; awvalid = 1; wvalid = 1; wlast = 0; cyc(); awvalid = 0;
    push_exp("t3_bypass", 12'h000, 1'b0, 1, 0);
    wlast = 1; cyc(); wvalid = 0; wlast = 0;
    push_exp("t3_clean", 12'h000, 1'b0, 0, 0);
    bvalid = 1; cyc(); bvalid = 0;
    push_exp("t3_clean_b", 12'h000, 1'b0, 0, 0);

    // AW FIFO fill, overflow, then push+pop at full.
    awlen = 0; awvalid = 1;
    for (int i = 0; i < MO; i++) cyc();
    push_exp("t4_fill", 12'h000, 1'b0, MO, 0);
    cyc();
    push_exp("t4_ovf", 12'h200, 1'b1, MO, 0);
    wvalid = 1; wlast = 1; cyc(); awvalid = 0;
    push_exp("t4_swap", 12'h200, 1'b0, MO, 0);
    for (int i = 0; i < MO; i++) cyc();
    wvalid = 0; wlast = 0;
    push_exp("t4_wdrain", 12'h200, 1'b0, 0, 0);
    bvalid = 1;
    for (int i = 0; i < MO + 1; i++) cyc();
    bvalid = 0;
    clear_flags("t4_clr", 0, 0);

    // Orphan B, then R in the same cycle as the first AR.
    bvalid = 1; cyc(); bvalid = 0;
    push_exp("t5_orphan_b", 12'h080, 1'b1, 0, 0);
    arvalid = 1; rvalid = 1; rlast = 1; cyc(); arvalid = 0;
    push_exp("t5_orphan_r", 12'h180, 1'b1, 0, 1);
    cyc(); rvalid = 0; rlast = 0;
    push_exp("t5_r_done", 12'h180, 1'b0, 0, 0);
    clear_flags("t5_clr", 0, 0);

    // Read-outstanding limit.
    arvalid = 1;
    for (int i = 0; i < MO; i++) cyc();
    push_exp("t6_fill", 12'h000, 1'b0, 0, MO);
    cyc();
    push_exp("t6_ovf", 12'h400, 1'b1, 0, MO);
    rvalid = 1; rlast = 1; cyc(); arvalid = 0;
    push_exp("t6_swap", 12'h400, 1'b0, 0, MO);
    for (int i = 0; i < MO; i++) cyc();
    rvalid = 0; rlast = 0;
    push_exp("t6_drain", 12'h400, 1'b0, 0, 0);
    clear_flags("t6_clr", 0, 0);

    // Flag setting masked while checking is disabled.
    check_en = 0; bvalid = 1; cyc(); bvalid = 0; check_en = 1;
    push_exp("t7_mask", 12'h000, 1'b0, 0, 0);

    // Reset in the middle of a 4-beat burst, then a fresh burst.
    awlen = 3; awvalid = 1; cyc(); awvalid = 0;
    wvalid = 1; wlast = 0; cyc(); cyc(); wvalid = 0;
    push_exp("t8_mid", 12'h000, 1'b0, 1, 0);
    sig_reset = 0; cyc(); sig_reset = 1;
    push_exp("t8_rst", 12'h000, 1'b0, 0, 0);
    write_burst(8'd3, "t8");

    cyc(); cyc();
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
